// File: rtl/result_unloader_if.sv
// Write-side bus of the result unloader: one packed word per beat with its
// element address, qualified by a valid/ready handshake.
interface result_unloader_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [BUS_WIDTH-1:0]  result_data_out;
    logic [ADDR_WIDTH-1:0] result_wr_addr;
    logic                  result_wr_en;
    logic                  result_wr_ready;

    modport master (
        output result_data_out,
        output result_wr_addr,
        output result_wr_en,
        input  result_wr_ready
    );

    modport slave (
        input  result_data_out,
        input  result_wr_addr,
        input  result_wr_en,
        output result_wr_ready
    );
endinterface

// File: rtl/result_unloader.sv
// Captures the valid rows of a systolic-array result into a local buffer and
// drains them row-major as packed bus words over a valid/ready write port.
module result_unloader #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 16,
    parameter int BUS_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         unload_trigger,
    input  logic [$clog2(SIZE)-1:0]      valid_row_num,
    input  logic [$clog2(SIZE)-1:0]      valid_col_num,
    input  logic                         result_valid,
    input  logic signed [DATA_WIDTH-1:0] result_in [SIZE],
    result_unloader_if.master            wr_bus,
    output logic                         unloader_busy,
    output logic                         unloading_done
);

    localparam int ELEMS    = BUS_WIDTH / DATA_WIDTH;
    localparam int WORDS    = SIZE / ELEMS;
    localparam int ROW_W    = $clog2(SIZE);
    localparam int ADDR_W   = $clog2(SIZE * SIZE);
    localparam int WORD_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int ROW_BITS = SIZE * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [ROW_W-1:0]    rows_q,     rows_d;
    logic [ROW_W-1:0]    cols_q,     cols_d;
    logic [ROW_W-1:0]    row_cnt_q,  row_cnt_d;
    logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
    logic [BUS_WIDTH-1:0] data_q,    data_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic                wr_en_q,    wr_en_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic [ROW_BITS-1:0] buf_q [SIZE];
    logic [ROW_BITS-1:0] buf_d [SIZE];

    logic [ROW_BITS-1:0] row_in_s;
    logic [WORD_W-1:0]   last_word_s;
    logic                accept_s;
    logic                last_beat_s;

    // Columns beyond the latched count come out as zero lanes.
    function automatic logic [BUS_WIDTH-1:0] pack_word(
        input logic [ROW_BITS-1:0] row,
        input logic [WORD_W-1:0]   word,
        input logic [ROW_W-1:0]    cols
    );
        logic [BUS_WIDTH-1:0] w;
        int                   col;
        w = '0;
        for (int k = 0; k < ELEMS; k++) begin
            col = int'(word) * ELEMS + k;
            if ((col <= int'(cols)) && (col < SIZE)) begin
                w[k*DATA_WIDTH +: DATA_WIDTH] = row[col*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                w[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end
        end
        return w;
    endfunction

    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [ROW_W-1:0]  row,
        input logic [WORD_W-1:0] word
    );
        return ADDR_W'(int'(row) * SIZE + int'(word) * ELEMS);
    endfunction

    assign last_word_s = WORD_W'(int'(cols_q) / ELEMS);
    assign accept_s    = wr_en_q && wr_bus.result_wr_ready;
    assign last_beat_s = (row_cnt_q == rows_q) && (word_cnt_q == last_word_s);

    // Flatten the incoming row so a buffer entry is a single vector.
    always_comb begin
        row_in_s = '0;
        for (int c = 0; c < SIZE; c++) begin
            row_in_s[c*DATA_WIDTH +: DATA_WIDTH] = result_in[c];
        end
    end

    // Next-state, counters, buffer write and registered-output values.
    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        row_cnt_d  = row_cnt_q;
        word_cnt_d = word_cnt_q;
        data_d     = data_q;
        addr_d     = addr_q;
        wr_en_d    = wr_en_q;
        done_d     = 1'b0;
        buf_d      = buf_q;

        case (state_q)
            IDLE: begin
                wr_en_d = 1'b0;
                if (unload_trigger) begin
                    rows_d     = valid_row_num;
                    cols_d     = valid_col_num;
                    row_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = CAPTURE;
                end else begin
                    state_d = IDLE;
                end
            end

            CAPTURE: begin
                if (result_valid) begin
                    buf_d[row_cnt_q] = row_in_s;
                    if (row_cnt_q == rows_q) begin
                        // buf_d already holds this row, so a one-row result
                        // can be presented in the very first DRAIN cycle.
                        row_cnt_d  = '0;
                        word_cnt_d = '0;
                        wr_en_d    = 1'b1;
                        data_d     = pack_word(buf_d[0], {WORD_W{1'b0}}, cols_q);
                        addr_d     = '0;
                        state_d    = DRAIN;
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_W'(1);
                        state_d   = CAPTURE;
                    end
                end else begin
                    state_d = CAPTURE;
                end
            end

            DRAIN: begin
                if (accept_s) begin
                    if (last_beat_s) begin
                        wr_en_d    = 1'b0;
                        data_d     = '0;
                        addr_d     = '0;
                        row_cnt_d  = '0;
                        word_cnt_d = '0;
                        done_d     = 1'b1;
                        state_d    = DONE;
                    end else begin
                        if (word_cnt_q == last_word_s) begin
                            word_cnt_d = '0;
                            row_cnt_d  = row_cnt_q + ROW_W'(1);
                        end else begin
                            word_cnt_d = word_cnt_q + WORD_W'(1);
                            row_cnt_d  = row_cnt_q;
                        end
                        data_d  = pack_word(buf_q[row_cnt_d], word_cnt_d, cols_q);
                        addr_d  = word_addr(row_cnt_d, word_cnt_d);
                        state_d = DRAIN;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end

            DONE: begin
                wr_en_d = 1'b0;
                state_d = IDLE;
            end

            default: begin
                wr_en_d    = 1'b0;
                data_d     = '0;
                addr_d     = '0;
                row_cnt_d  = '0;
                word_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Control and output registers; reset aborts any sequence in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            row_cnt_q  <= '0;
            word_cnt_q <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            row_cnt_q  <= row_cnt_d;
            word_cnt_q <= word_cnt_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Row buffer; contents are always rewritten before being drained.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign wr_bus.result_data_out = data_q;
    assign wr_bus.result_wr_addr  = addr_q;
    assign wr_bus.result_wr_en    = wr_en_q;
    assign unloader_busy          = busy_q;
    assign unloading_done         = done_q;

endmodule

// File: tb/tb_result_unloader.sv
// Self-checking bench for result_unloader (SIZE=4, 8-bit elements, 32-bit bus);
// expected beats come from a row-major packing model over a stored matrix.
module tb_result_unloader;

    localparam int DW    = 8;
    localparam int SZ    = 4;
    localparam int BW    = 32;
    localparam int AW    = 4;
    localparam int ELEMS = BW / DW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 unload_trigger;
    logic [1:0]           valid_row_num;
    logic [1:0]           valid_col_num;
    logic                 result_valid;
    logic signed [DW-1:0] result_in [SZ];
    logic                 tb_ready;
    logic                 unloader_busy;
    logic                 unloading_done;

    result_unloader_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();
    assign bus.result_wr_ready = tb_ready;

    result_unloader #(.DATA_WIDTH(DW), .SIZE(SZ), .BUS_WIDTH(BW)) dut (
        .clk            (clk),
        .rst            (rst),
        .unload_trigger (unload_trigger),
        .valid_row_num  (valid_row_num),
        .valid_col_num  (valid_col_num),
        .result_valid   (result_valid),
        .result_in      (result_in),
        .wr_bus         (bus),
        .unloader_busy  (unloader_busy),
        .unloading_done (unloading_done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mat [SZ][SZ];
    beat_t got_q[$];
    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    hold_viol, done_pulses, drain_len, first_en, stall_cycles;
    bit    timed_out;

    task automatic build_exp(input int rows, input int cols);
        int    nw;
        beat_t b;
        exp_q.delete();
        nw = (cols + ELEMS) / ELEMS;
        for (int r = 0; r <= rows; r++) begin
            for (int w = 0; w < nw; w++) begin
                b.addr = AW'(r * SZ + w * ELEMS);
                b.data = '0;
                for (int k = 0; k < ELEMS; k++) begin
                    if (w * ELEMS + k <= cols) b.data[k*DW +: DW] = mat[r][w*ELEMS+k];
                end
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic load(input int rows, input int cols, input bit trig_mid, input bit noisy);
        unload_trigger = 1'b1;
        valid_row_num  = 2'(rows);
        valid_col_num  = 2'(cols);
        result_valid   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int c = 0; c < SZ; c++) result_in[c] = 8'($urandom);
        @(posedge clk); #1;
        unload_trigger = 1'b0;
        for (int r = 0; r <= rows; r++) begin
            if (noisy) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    result_valid = 1'b0;
                    for (int c = 0; c < SZ; c++) result_in[c] = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            result_valid = 1'b1;
            for (int c = 0; c < SZ; c++) result_in[c] = mat[r][c];
            if (trig_mid && r == 1) begin
                unload_trigger = 1'b1;
                valid_row_num  = 2'd0;
                valid_col_num  = 2'd0;
            end
            @(posedge clk); #1;
            unload_trigger = 1'b0;
        end
        result_valid = 1'b0;
    endtask

    // mode 0: ready always high, 1: random ready, 2: stall beat 1 for stall_len cycles
    task automatic collect(input int mode, input int stall_len, input int abort_at, input bit noisy);
        bit            fin, prev_stall, rdy;
        logic          en;
        logic [AW-1:0] pa;
        logic [BW-1:0] pd;
        got_q.delete();
        hold_viol = 0; done_pulses = 0; drain_len = -1; first_en = -1;
        stall_cycles = 0; timed_out = 1'b0; fin = 1'b0; prev_stall = 1'b0;
        pa = '0; pd = '0;
        for (int i = 0; i < 400 && !fin; i++) begin
            en = bus.result_wr_en;
            if (prev_stall && (en !== 1'b1 || bus.result_wr_addr !== pa || bus.result_data_out !== pd))
                hold_viol++;
            if (unloading_done === 1'b1) begin
                done_pulses++;
                if (drain_len < 0 && first_en >= 0) drain_len = i - first_en;
            end
            if (en === 1'b1 && first_en < 0) first_en = i;
            if (abort_at >= 0 && got_q.size() == abort_at) begin
                tb_ready = 1'b0;
                fin = 1'b1;
            end else if (done_pulses > 0 && unloader_busy === 1'b0) begin
                fin = 1'b1;
            end else begin
                if (mode == 1)      rdy = ($urandom_range(0, 99) < 70);
                else if (mode == 2) rdy = !(got_q.size() == 1 && stall_cycles < stall_len);
                else                rdy = 1'b1;
                tb_ready = rdy;
                if (noisy) begin
                    result_valid = 1'($urandom_range(0, 1));
                    for (int c = 0; c < SZ; c++) result_in[c] = 8'($urandom);
                end
                if (en === 1'b1 && rdy) got_q.push_back({bus.result_wr_addr, bus.result_data_out});
                if (en === 1'b1 && !rdy) begin
                    stall_cycles++;
                    prev_stall = 1'b1;
                    pa = bus.result_wr_addr;
                    pd = bus.result_data_out;
                end else begin
                    prev_stall = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        result_valid = 1'b0;
        if (!fin) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; unload_trigger = 1'b0; valid_row_num = 2'd0; valid_col_num = 2'd0;
        result_valid = 1'b0; tb_ready = 1'b1;
        for (int c = 0; c < SZ; c++) result_in[c] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.result_wr_en !== 1'b0) $display("FAIL reset_en: got %b want 0", bus.result_wr_en); else n_pass++;
        n_checks++; if (unloader_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", unloader_busy); else n_pass++;
        n_checks++; if (unloading_done !== 1'b0) $display("FAIL reset_done: got %b want 0", unloading_done); else n_pass++;
        n_checks++; if (bus.result_data_out !== 32'h0) $display("FAIL reset_data: got %h want 0", bus.result_data_out); else n_pass++;
        n_checks++; if (bus.result_wr_addr !== 4'h0) $display("FAIL reset_addr: got %h want 0", bus.result_wr_addr); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full();
        for (int r = 0; r < SZ; r++) for (int c = 0; c < SZ; c++) mat[r][c] = 8'(16 * r + c);
        build_exp(3, 3);
        load(3, 3, 1'b0, 1'b0);
        n_checks++; if (unloader_busy !== 1'b1) $display("FAIL full_busy: got %b want 1", unloader_busy); else n_pass++;
        collect(0, 0, -1, 1'b0);
        n_checks++; if (timed_out) $display("FAIL full_timeout: got timeout want done"); else n_pass++;
        n_checks++; if (first_en !== 0) $display("FAIL full_first_en: got cycle %0d want 0", first_en); else n_pass++;
        n_checks++; if (got_q.size() !== 4) $display("FAIL full_count: got %0d want 4", got_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i])
                $display("FAIL full_beat%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (got_q.size() < 1 || got_q[0].data !== 32'h03020100)
            $display("FAIL full_beat0_const: got %h want 03020100", (got_q.size() > 0) ? got_q[0].data : '0); else n_pass++;
        n_checks++; if (done_pulses !== 1) $display("FAIL full_done_pulses: got %0d want 1", done_pulses); else n_pass++;
        n_checks++; if (drain_len !== 4) $display("FAIL full_done_timing: got %0d want 4", drain_len); else n_pass++;
    endtask

    task automatic test_partial();
        for (int c = 0; c < SZ; c++) begin
            mat[0][c] = 8'(c + 1);
            mat[1][c] = 8'(c + 5);
        end
        build_exp(1, 2);
        load(1, 2, 1'b0, 1'b0);
        collect(0, 0, -1, 1'b0);
        n_checks++; if (got_q.size() !== 2) $display("FAIL partial_count: got %0d want 2", got_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i])
                $display("FAIL partial_beat%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (got_q.size() < 2 || got_q[1] !== {4'd4, 32'h00070605})
            $display("FAIL partial_beat1_const: got %h want 400070605", (got_q.size() > 1) ? got_q[1] : '0); else n_pass++;
        n_checks++; if (drain_len !== 2) $display("FAIL partial_drain_len: got %0d want 2", drain_len); else n_pass++;
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < SZ; r++) for (int c = 0; c < SZ; c++) mat[r][c] = 8'($urandom);
        build_exp(3, 3);
        load(3, 3, 1'b0, 1'b0);
        collect(2, 3, -1, 1'b0);
        n_checks++; if (got_q.size() !== 4) $display("FAIL bp_count: got %0d want 4", got_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i])
                $display("FAIL bp_beat%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (stall_cycles !== 3) $display("FAIL bp_stalls: got %0d want 3", stall_cycles); else n_pass++;
        n_checks++; if (hold_viol !== 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_viol); else n_pass++;
        n_checks++; if (drain_len !== 7) $display("FAIL bp_drain_len: got %0d want 7", drain_len); else n_pass++;
        n_checks++; if (done_pulses !== 1) $display("FAIL bp_done: got %0d want 1", done_pulses); else n_pass++;
    endtask

    task automatic test_trigger_ignored();
        for (int r = 0; r < SZ; r++) for (int c = 0; c < SZ; c++) mat[r][c] = 8'($urandom_range(1, 255));
        build_exp(3, 3);
        load(3, 3, 1'b1, 1'b0);
        collect(0, 0, -1, 1'b0);
        n_checks++; if (got_q.size() !== 4) $display("FAIL trig_count: got %0d want 4", got_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i])
                $display("FAIL trig_beat%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_abort();
        int en_seen, done_seen;
        for (int r = 0; r < SZ; r++) for (int c = 0; c < SZ; c++) mat[r][c] = 8'(16 * r + c);
        load(3, 3, 1'b0, 1'b0);
        collect(0, 0, 2, 1'b0);
        n_checks++; if (got_q.size() !== 2) $display("FAIL abort_pre_beats: got %0d want 2", got_q.size()); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (bus.result_wr_en !== 1'b0) $display("FAIL abort_en: got %b want 0", bus.result_wr_en); else n_pass++;
        n_checks++; if (unloader_busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", unloader_busy); else n_pass++;
        en_seen = 0; done_seen = 0;
        tb_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.result_wr_en === 1'b1) en_seen++;
            if (unloading_done === 1'b1) done_seen++;
            @(posedge clk); #1;
        end
        n_checks++; if (en_seen !== 0) $display("FAIL abort_no_beats: got %0d en cycles want 0", en_seen); else n_pass++;
        n_checks++; if (done_seen !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); else n_pass++;
        for (int c = 0; c < SZ; c++) mat[0][c] = 8'($urandom_range(1, 255));
        build_exp(0, 0);
        load(0, 0, 1'b0, 1'b0);
        collect(0, 0, -1, 1'b0);
        n_checks++; if (got_q.size() !== 1) $display("FAIL one_count: got %0d want 1", got_q.size()); else n_pass++;
        n_checks++; if (got_q.size() < 1 || got_q[0] !== exp_q[0])
            $display("FAIL one_beat: got %h want %h", (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]); else n_pass++;
        n_checks++; if (got_q.size() < 1 || got_q[0].data[31:8] !== 24'h0 || got_q[0].addr !== 4'd0)
            $display("FAIL one_zero_lanes: got %h want upper lanes 0 at addr 0", (got_q.size() > 0) ? got_q[0] : '0); else n_pass++;
        n_checks++; if (done_pulses !== 1) $display("FAIL one_done: got %0d want 1", done_pulses); else n_pass++;
    endtask

    task automatic test_random();
        int rows, cols;
        for (int it = 0; it < 12; it++) begin
            rows = $urandom_range(0, 3);
            cols = $urandom_range(0, 3);
            for (int r = 0; r < SZ; r++) for (int c = 0; c < SZ; c++) mat[r][c] = 8'($urandom);
            build_exp(rows, cols);
            load(rows, cols, 1'b0, 1'b1);
            collect(1, 0, -1, 1'b1);
            n_checks++; if (timed_out) $display("FAIL rnd%0d_timeout: got timeout want done", it); else n_pass++;
            n_checks++; if (got_q.size() !== exp_q.size())
                $display("FAIL rnd%0d_count: got %0d want %0d", it, got_q.size(), exp_q.size()); else n_pass++;
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i])
                    $display("FAIL rnd%0d_beat%0d: got %h want %h", it, i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
                else n_pass++;
            end
            n_checks++; if (hold_viol !== 0) $display("FAIL rnd%0d_hold: got %0d want 0", it, hold_viol); else n_pass++;
            n_checks++; if (done_pulses !== 1) $display("FAIL rnd%0d_done: got %0d want 1", it, done_pulses); else n_pass++;
            n_checks++; if (drain_len !== exp_q.size() + stall_cycles)
                $display("FAIL rnd%0d_drain_len: got %0d want %0d", it, drain_len, exp_q.size() + stall_cycles); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_partial();
        test_backpressure();
        test_trigger_ignored();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/result_unloader.md
RESULT_UNLOADER -- requirements
Module: result_unloader

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning the result element width in bits.
REQ-002 The module SHALL have parameter SIZE, default 16, meaning the array dimension.
REQ-003 The module SHALL have parameter BUS_WIDTH, default 32, meaning the output bus width; BUS_WIDTH SHALL be a multiple of DATA_WIDTH, ELEMS = BUS_WIDTH/DATA_WIDTH, and SIZE SHALL be a multiple of ELEMS.
REQ-004 Port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge clk.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port unload_trigger, input, 1 bit: a one-cycle pulse that starts a capture/drain sequence.
REQ-007 Port valid_row_num, input, $clog2(SIZE) bits: valid row count minus 1.
REQ-008 Port valid_col_num, input, $clog2(SIZE) bits: valid column count minus 1.
REQ-009 Port result_valid, input, 1 bit: result_in holds one array output row.
REQ-010 Port result_in, input, signed [DATA_WIDTH-1:0] x SIZE unpacked: one row from the array, column c in element c.
REQ-011 Port result_data_out, output reg, BUS_WIDTH bits: packed result word.
REQ-012 Port result_wr_addr, output reg, $clog2(SIZE*SIZE) bits: element index of lane 0 of the word.
REQ-013 Port result_wr_en, output reg, 1 bit: word valid.
REQ-014 Port result_wr_ready, input, 1 bit: the sink accepts the word.
REQ-015 Port unloader_busy, output reg, 1 bit: high in any state other than IDLE.
REQ-016 Port unloading_done, output reg, 1 bit: one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, CAPTURE, DRAIN and DONE.
REQ-018 In IDLE, unload_trigger SHALL latch valid_row_num and valid_col_num, clear the counters and enter CAPTURE on the next cycle.
REQ-019 unload_trigger SHALL be ignored outside IDLE, and the latched sizes SHALL stay stable until the module returns to IDLE.
REQ-020 In CAPTURE, each cycle with result_valid high SHALL write result_in into buffer row row_cnt and increment row_cnt.
REQ-021 Capture of row latched_rows SHALL clear row_cnt and move the FSM to DRAIN; result_wr_en SHALL be high in the first DRAIN cycle.
REQ-022 result_valid SHALL be ignored outside CAPTURE.
REQ-023 DRAIN SHALL emit words in row-major order: rows 0..latched_rows, and per row word indices 0..W-1, where W = ceil((latched_cols+1)/ELEMS).
REQ-024 Word w of row r SHALL carry elements r, w*ELEMS+k in lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-025 Lanes whose column index exceeds latched_cols SHALL be driven zero.
REQ-026 result_wr_addr SHALL equal r*SIZE + w*ELEMS.
REQ-027 While result_wr_en is high and result_wr_ready is low, result_data_out and result_wr_addr SHALL hold stable.
REQ-028 A beat SHALL be accepted on a cycle where result_wr_en and result_wr_ready are both high; the next word SHALL be presented on the following cycle with no bubble.
REQ-029 After the last word (r = latched_rows, w = W-1) is accepted, result_wr_en SHALL drop and the FSM SHALL enter DONE.
REQ-030 In DONE, unloading_done SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-031 result_wr_en SHALL be high only in DRAIN.
REQ-032 Minimum drain time SHALL be (latched_rows+1)*W cycles when result_wr_ready is held high.

Reset
REQ-033 While rst is high, the FSM SHALL go to IDLE, clear counters and latched sizes, and drive result_wr_en=0, unloader_busy=0, unloading_done=0, result_data_out=0 and result_wr_addr=0.
REQ-034 rst asserted mid-CAPTURE or mid-DRAIN SHALL abort the sequence with no further beats and no unloading_done pulse.
REQ-035 Buffer contents need not be reset.

Verification (SIZE=4, DATA_WIDTH=8, BUS_WIDTH=32, ELEMS=4)
REQ-036 Full 4x4: trigger with sizes 3/3, then 4 rows where element(r,c)=16r+c -> 4 beats with addr 0,4,8,12, beat 0 = 0x03020100, and done one cycle after the last beat.
REQ-037 Partial: sizes 1/2, rows {1,2,3,4},{5,6,7,8} -> 2 beats, 0x00030201@0 and 0x00070605@4.
REQ-038 Backpressure: ready low for 3 cycles on beat 1 -> beat 1 data/addr held for 4 cycles, no beat lost or duplicated, total beat count unchanged.
REQ-039 Trigger pulsed during CAPTURE with different sizes -> ignored; the original sizes govern the beat count.
REQ-040 rst for 1 cycle after beat 1 of the 4x4 case -> result_wr_en=0 and busy=0 next cycle, no done; a following 1x1 run (sizes 0/0) yields a single beat with lanes 1-3 zero, addr 0.
